// File: rtl/enc_pulse_sampler_pkg.sv
// Shared constants and state encoding for the encoder pulse sampler.
package enc_pulse_sampler_pkg;

  localparam int SAMPLE_TICKS_DEF = 500000;
  localparam int CNT_W_DEF        = 14;
  localparam int FILT_LEN_DEF     = 4;
  localparam int CNT_MAX          = (1 << CNT_W_DEF) - 1;

  typedef enum logic {
    S_RUN      = 1'b0,
    S_ACK_WAIT = 1'b1
  } state_t;

  function automatic int cnt_max(input int w);
    return (1 << w) - 1;
  endfunction

endpackage

// File: rtl/enc_input_cond.sv
// Encoder input conditioning: 2-flop synchronizer, optional stability filter
// (ENC_GLITCH_FILTER_EN), and rising-edge detector producing a one-cycle pulse.
module enc_input_cond
  import enc_pulse_sampler_pkg::*;
#(
  parameter int FILT_LEN = FILT_LEN_DEF
) (
  input  logic i_Clk,
  input  logic reset,
  input  logic i_enc_a,
  output logic o_edge
);

  logic sync1_q, sync2_q, prev_q;
  logic level;

  if (FILT_LEN < 1) begin : g_filt_len_check
    $error("enc_input_cond: FILT_LEN must be >= 1");
  end

`ifdef ENC_GLITCH_FILTER_EN
  localparam int FCW = $clog2(FILT_LEN + 1);
  logic           filt_q;
  logic [FCW-1:0] fcnt_q;

  // Level follows the synchronized input only after FILT_LEN disagreeing samples in a row.
  always_ff @(posedge i_Clk or posedge reset) begin
    if (reset) begin
      filt_q <= 1'b0;
      fcnt_q <= '0;
    end else if (sync2_q != filt_q) begin
      if (fcnt_q == FCW'(FILT_LEN - 1)) begin
        filt_q <= sync2_q;
        fcnt_q <= '0;
      end else begin
        fcnt_q <= fcnt_q + 1'b1;
      end
    end else begin
      fcnt_q <= '0;
    end
  end

  assign level = filt_q;
`else
  assign level = sync2_q;
`endif

  always_ff @(posedge i_Clk or posedge reset) begin
    if (reset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      prev_q  <= 1'b0;
    end else begin
      sync1_q <= i_enc_a;
      sync2_q <= sync1_q;
      prev_q  <= level;
    end
  end

  assign o_edge = level & ~prev_q;

endmodule

// File: rtl/enc_pulse_sampler.sv
// Counts encoder rising edges per fixed window, strobes the result to the PID
// and tracks its reset_nop acknowledge. Glitch filter option: ENC_GLITCH_FILTER_EN.
module enc_pulse_sampler
  import enc_pulse_sampler_pkg::*;
#(
  parameter int SAMPLE_TICKS = SAMPLE_TICKS_DEF,
  parameter int CNT_W        = CNT_W_DEF,
  parameter int FILT_LEN     = FILT_LEN_DEF
) (
  input  logic             i_Clk,
  input  logic             reset,
  input  logic             i_enable,
  input  logic             i_enc_a,
  input  logic             i_reset_nop,
  output logic [CNT_W-1:0] o_number_of_pulses,
  output logic             o_pid_timer,
  output logic             o_overflow,
  output logic             o_ack_err
);

  localparam int             TW        = $clog2(SAMPLE_TICKS);
  localparam logic [TW-1:0]  TICK_LAST = TW'(SAMPLE_TICKS - 1);
  localparam logic [CNT_W-1:0] CNT_SAT = CNT_W'(cnt_max(CNT_W));

  if (SAMPLE_TICKS < 16) begin : g_ticks_check
    $error("enc_pulse_sampler: SAMPLE_TICKS must be >= 16");
  end

  logic             edge_w;
  logic [TW-1:0]    tick_q;
  logic [CNT_W-1:0] live_q, live_d;
  logic             live_ovf_q, live_ovf_d;
  logic [CNT_W-1:0] num_q;
  logic             ovf_q, strobe_q, err_q;
  state_t           state_q;
  logic             term, at_max;

  enc_input_cond #(.FILT_LEN(FILT_LEN)) u_cond (
    .i_Clk  (i_Clk),
    .reset  (reset),
    .i_enc_a(i_enc_a),
    .o_edge (edge_w)
  );

  assign term       = (tick_q == TICK_LAST) & i_enable;
  assign at_max     = (live_q == CNT_SAT);
  assign live_d     = (edge_w & ~at_max) ? live_q + 1'b1 : live_q;
  assign live_ovf_d = live_ovf_q | (edge_w & at_max);

  always_ff @(posedge i_Clk or posedge reset) begin
    if (reset) begin
      tick_q     <= '0;
      live_q     <= '0;
      live_ovf_q <= 1'b0;
      num_q      <= '0;
      ovf_q      <= 1'b0;
      strobe_q   <= 1'b0;
      err_q      <= 1'b0;
      state_q    <= S_RUN;
    end else if (!i_enable) begin
      tick_q     <= '0;
      live_q     <= '0;
      live_ovf_q <= 1'b0;
      strobe_q   <= 1'b0;
      state_q    <= S_RUN;
    end else begin
      strobe_q <= term;
      if (term) begin
        tick_q     <= '0;
        num_q      <= live_d;
        ovf_q      <= live_ovf_d;
        live_q     <= '0;
        live_ovf_q <= 1'b0;
      end else begin
        tick_q     <= tick_q + 1'b1;
        live_q     <= live_d;
        live_ovf_q <= live_ovf_d;
      end
      // An ack landing on a term cycle answers the old strobe; the new one is still pending.
      case (state_q)
        S_RUN: begin
          if (term) state_q <= S_ACK_WAIT;
        end
        S_ACK_WAIT: begin
          if (term && !i_reset_nop) err_q <= 1'b1;
          else if (!term && i_reset_nop) state_q <= S_RUN;
        end
        default: state_q <= S_RUN;
      endcase
    end
  end

  assign o_number_of_pulses = num_q;
  assign o_overflow         = ovf_q;
  assign o_pid_timer        = strobe_q;
  assign o_ack_err          = err_q;

endmodule

// File: tb/tb_enc_pulse_sampler.sv
// Directed bench for enc_pulse_sampler: table of per-window vectors plus
// hand-written boundary, ack-error, reset and enable sequences.
module tb_enc_pulse_sampler;

  localparam int ST = 100;
  localparam int CW = 4;
  localparam int FL = 4;
`ifdef ENC_GLITCH_FILTER_EN
  localparam int LAT    = 3 + FL;
  localparam int R1_CNT = 0;
  localparam int R1_OVF = 0;
  localparam int R3_CNT = 3;
`else
  localparam int LAT    = 3;
  localparam int R1_CNT = 15;
  localparam int R1_OVF = 1;
  localparam int R3_CNT = 6;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          en  = 1'b1;
  logic          enc = 1'b0;
  logic          nop = 1'b0;
  logic [CW-1:0] cnt_o;
  logic          pid_o, ovf_o, err_o;

  always #5 clk = ~clk;

  enc_pulse_sampler #(.SAMPLE_TICKS(ST), .CNT_W(CW), .FILT_LEN(FL)) dut (
    .i_Clk             (clk),
    .reset             (rst),
    .i_enable          (en),
    .i_enc_a           (enc),
    .i_reset_nop       (nop),
    .o_number_of_pulses(cnt_o),
    .o_pid_timer       (pid_o),
    .o_overflow        (ovf_o),
    .o_ack_err         (err_o)
  );

  typedef struct {
    int na, ha, la;
    int nb, hb, lb;
    bit ack;
    int ec, eo, ee;
  } vec_t;

  vec_t tbl[7];
  int   n_chk = 0;
  int   n_pass = 0;
  int   cyc = 0;
  int   last_cnt = 0;
  bit   ack_pending = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  task automatic step();
    @(negedge clk);
    cyc++;
  endtask

  task automatic goto(input int c);
    while (cyc < c) step();
  endtask

  task automatic pulses(input int n, input int hi, input int lo);
    repeat (n) begin
      enc = 1'b1;
      repeat (hi) step();
      enc = 1'b0;
      repeat (lo) step();
    end
  endtask

  // Strobe must appear on exactly the window-end cycle, with the count alongside.
  task automatic check_strobe(input string tag, input int end_c, input int ec,
                              input int eo, input int ee, input bit ack);
    goto(end_c - 1);
    chk({tag, " pre_idle"}, pid_o, 0);
    chk({tag, " hold"}, cnt_o, last_cnt);
    goto(end_c);
    chk({tag, " strobe"}, pid_o, 1);
    chk({tag, " count"}, cnt_o, ec);
    chk({tag, " ovf"}, ovf_o, eo);
    chk({tag, " ack_err"}, err_o, ee);
    $display("window %s: count=%0d ovf=%0d ack_err=%0d", tag, cnt_o, ovf_o, err_o);
    last_cnt = ec;
    if (ack) ack_pending = 1'b1;
    step();
    chk({tag, " post_idle"}, pid_o, 0);
  endtask

  // PID model: answers a requested strobe with a one-cycle reset_nop.
  initial begin
    forever begin
      @(negedge clk);
      if (ack_pending) begin
        ack_pending = 1'b0;
        nop = 1'b1;
        @(negedge clk);
        nop = 1'b0;
      end
    end
  end

  initial begin
    int  wbase;
    bit  saw;
    tbl[0] = '{7, 5, 5, 0, 0, 0, 1'b1, 7, 0, 0};
    tbl[1] = '{20, 2, 2, 0, 0, 0, 1'b1, R1_CNT, R1_OVF, 0};
    tbl[2] = '{3, 5, 5, 0, 0, 0, 1'b1, 3, 0, 0};
    tbl[3] = '{3, 2, 6, 3, 8, 8, 1'b1, R3_CNT, 0, 0};
    tbl[4] = '{2, 5, 5, 0, 0, 0, 1'b0, 2, 0, 0};
    tbl[5] = '{1, 5, 5, 0, 0, 0, 1'b0, 1, 0, 1};
    tbl[6] = '{0, 0, 0, 0, 0, 0, 1'b1, 0, 0, 1};

    repeat (3) @(negedge clk);
    chk("reset count", cnt_o, 0);
    chk("reset strobe", pid_o, 0);
    chk("reset ovf", ovf_o, 0);
    chk("reset ack_err", err_o, 0);
    rst = 1'b0;
    cyc = 0;

    wbase = 0;
    for (int r = 0; r < 7; r++) begin
      pulses(tbl[r].na, tbl[r].ha, tbl[r].la);
      pulses(tbl[r].nb, tbl[r].hb, tbl[r].lb);
      check_strobe($sformatf("row%0d", r), wbase + ST, tbl[r].ec, tbl[r].eo,
                   tbl[r].ee, tbl[r].ack);
      wbase += ST;
    end

    // Last countable rise before the term cycle, then one that just misses it.
    pulses(2, 5, 5);
    goto(wbase + ST - LAT);
    enc = 1'b1;
    check_strobe("bnd_in", wbase + ST, 3, 0, 1, 1'b1);
    wbase += ST;
    goto(wbase + 6);
    enc = 1'b0;
    goto(wbase + 20);
    enc = 1'b1;
    goto(wbase + 25);
    enc = 1'b0;
    goto(wbase + ST + 1 - LAT);
    enc = 1'b1;
    check_strobe("bnd_miss", wbase + ST, 1, 0, 1, 1'b1);
    wbase += ST;
    goto(wbase + 9);
    enc = 1'b0;
    check_strobe("bnd_next", wbase + ST, 1, 0, 1, 1'b1);
    wbase += ST;

    // Asynchronous reset mid-window with 5 pulses already counted.
    pulses(5, 5, 5);
    goto(wbase + 60);
    #2 rst = 1'b1;
    #1;
    chk("async count", cnt_o, 0);
    chk("async strobe", pid_o, 0);
    chk("async ovf", ovf_o, 0);
    chk("async ack_err", err_o, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    cyc = 0;
    last_cnt = 0;
    pulses(2, 5, 5);
    check_strobe("post_rst", ST, 2, 0, 0, 1'b1);

    // Disable mid-window: partial count dropped, no strobes, outputs held.
    wbase = ST;
    pulses(3, 5, 5);
    goto(wbase + 40);
    en = 1'b0;
    saw = 1'b0;
    repeat (15) begin
      enc = 1'b1;
      repeat (5) begin step(); if (pid_o) saw = 1'b1; end
      enc = 1'b0;
      repeat (5) begin step(); if (pid_o) saw = 1'b1; end
    end
    repeat (10) begin step(); if (pid_o) saw = 1'b1; end
    chk("disabled no_strobe", saw, 0);
    chk("disabled hold count", cnt_o, 2);
    en = 1'b1;
    cyc = 0;
    pulses(4, 5, 5);
    check_strobe("reenable", ST, 4, 0, 0, 1'b1);

    repeat (5) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
